// File: rtl/mult_share_arb_7.sv
// Round-robin sharing of one combinational 4x4 array multiplier between up to
// four valid/ready requesters, with a held product register per requester.

module fbf_mult_7 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    // Shift-and-add array: one ripple-carry row per multiplier bit.
    always_comb begin
        logic [3:0] w_pp;
        logic [3:0] w_acc;
        logic [3:0] w_sum;
        logic       w_c;
        o_p    = '0;
        w_pp   = i_a & {4{i_b[0]}};
        o_p[0] = w_pp[0];
        w_acc  = {1'b0, w_pp[3:1]};
        w_sum  = '0;
        w_c    = 1'b0;
        for (int r = 1; r < 4; r++) begin
            w_pp = i_a & {4{i_b[r]}};
            w_c  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w_sum[k] = w_acc[k] ^ w_pp[k] ^ w_c;
                w_c      = (w_acc[k] & w_pp[k]) | (w_acc[k] & w_c) | (w_pp[k] & w_c);
            end
            o_p[r] = w_sum[0];
            w_acc  = {w_c, w_sum[3:1]};
        end
        o_p[7:4] = w_acc;
    end

endmodule

module mult_share_arb_7 #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_a,
    input  logic [4*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [8*NREQ-1:0]    resp_p,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic [CNTW-1:0]      op_count
);

    localparam int unsigned OPW = 4;
    localparam int unsigned PRW = 8;
    localparam int unsigned IDW = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MULT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IDW-1:0]         r_rr_ptr;
    logic [IDW-1:0]         r_grant_id;
    logic [OPW-1:0]         r_a;
    logic [OPW-1:0]         r_b;
    logic [NREQ-1:0]        r_resp_valid;
    logic [PRW*NREQ-1:0]    r_resp_p;
    logic [CNTW-1:0]        r_op_count;

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_req_ready;
    logic                   w_found;
    logic [IDW-1:0]         w_win;
    logic [IDW-1:0]         w_next_ptr;
    logic [OPW-1:0]         w_win_a;
    logic [OPW-1:0]         w_win_b;
    logic [PRW-1:0]         w_prod;

    // A held, unconsumed product blocks its requester from a new grant.
    assign w_elig = req_valid & ~r_resp_valid;

    // Round-robin search: indices at/above the pointer first, then the wrap-around.
    always_comb begin
        w_req_ready = '0;
        w_found     = 1'b0;
        w_win       = '0;
        w_win_a     = '0;
        w_win_b     = '0;
        if (rst && (r_state == S_IDLE)) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!w_found && w_elig[i] && (IDW'(i) >= r_rr_ptr)) begin
                    w_found        = 1'b1;
                    w_win          = IDW'(i);
                    w_req_ready[i] = 1'b1;
                    w_win_a        = req_a[OPW*i +: OPW];
                    w_win_b        = req_b[OPW*i +: OPW];
                end
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!w_found && w_elig[i] && (IDW'(i) < r_rr_ptr)) begin
                    w_found        = 1'b1;
                    w_win          = IDW'(i);
                    w_req_ready[i] = 1'b1;
                    w_win_a        = req_a[OPW*i +: OPW];
                    w_win_b        = req_b[OPW*i +: OPW];
                end
            end
        end
    end

    assign w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : (w_win + IDW'(1));

    fbf_mult_7 u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Sequencer: IDLE accepts a winner, MULT writes the product into its slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_resp_valid <= '0;
            r_resp_p     <= '0;
            r_op_count   <= '0;
        end else begin
            r_resp_valid <= r_resp_valid & ~resp_ready;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a        <= w_win_a;
                        r_b        <= w_win_b;
                        r_grant_id <= w_win;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= S_MULT;
                    end
                end
                S_MULT: begin
                    // Slot was empty at accept, so the set here always wins over a clear.
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (r_grant_id == IDW'(i)) begin
                            r_resp_valid[i]          <= 1'b1;
                            r_resp_p[PRW*i +: PRW]   <= w_prod;
                        end
                    end
                    if (r_op_count != '1) begin
                        r_op_count <= r_op_count + CNTW'(1);
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_p     = r_resp_p;
    assign busy       = (r_state == S_MULT);
    assign grant_id   = r_grant_id;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_mult_share_arb_7.sv
// Bench for mult_share_arb_7: directed scenarios, a per-cycle reference model,
// and a second instance with an 8-bit counter to exercise saturation.

module tb_mult_share_arb_7;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  resp_ready;

    logic [3:0]  req_ready,  req_ready8;
    logic [3:0]  resp_valid, resp_valid8;
    logic [31:0] resp_p,     resp_p8;
    logic        busy,       busy8;
    logic [1:0]  grant_id,   grant_id8;
    logic [15:0] op_count;
    logic [7:0]  op_count8;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    bit          m_init = 1'b0;
    bit          m_rv [N];
    logic [7:0]  m_rp [N];
    int          m_ptr, m_gid, m_a, m_b, m_cnt;
    bit          m_busy;

    int acc_id [$];
    int acc_cyc [$];

    mult_share_arb_7 #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_p(resp_p), .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    mult_share_arb_7 #(.NREQ(4), .CNTW(8)) dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready8), .resp_valid(resp_valid8), .resp_ready(resp_ready),
        .resp_p(resp_p8), .busy(busy8), .grant_id(grant_id8), .op_count(op_count8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare against the model on every falling edge, then advance the model
    // across the coming rising edge using the (already stable) inputs.
    always @(negedge clk) begin : cmp_p
        logic [3:0]  e_ready;
        logic [3:0]  e_rv;
        logic [31:0] e_rp;
        int          w;
        int          idx;
        e_ready = '0;
        e_rv    = '0;
        e_rp    = '0;
        w       = -1;
        if (rst && !m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req_valid[idx] && !m_rv[idx]) w = idx;
            end
        end
        if (w >= 0) e_ready[w] = 1'b1;
        for (int i = 0; i < N; i++) begin
            e_rv[i]       = m_rv[i];
            e_rp[8*i +: 8] = m_rp[i];
        end
        if (m_init) begin
            chk("req_ready",   64'(req_ready),   64'(e_ready));
            chk("resp_valid",  64'(resp_valid),  64'(e_rv));
            chk("resp_p",      64'(resp_p),      64'(e_rp));
            chk("busy",        64'(busy),        64'(m_busy));
            chk("grant_id",    64'(grant_id),    64'(m_gid));
            chk("op_count",    64'(op_count),    64'(m_cnt));
            chk("req_ready8",  64'(req_ready8),  64'(e_ready));
            chk("resp_valid8", 64'(resp_valid8), 64'(e_rv));
            chk("resp_p8",     64'(resp_p8),     64'(e_rp));
            chk("busy8",       64'(busy8),       64'(m_busy));
            chk("grant_id8",   64'(grant_id8),   64'(m_gid));
            chk("op_count8",   64'(op_count8),   64'((m_cnt > 255) ? 255 : m_cnt));
        end
        if (rst && ((req_valid & req_ready) != 4'b0)) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) acc_id.push_back(i);
            acc_cyc.push_back(cyc);
        end
        if (!rst) begin
            m_init = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_rv[i] = 1'b0;
                m_rp[i] = 8'd0;
            end
            m_ptr = 0; m_gid = 0; m_a = 0; m_b = 0; m_cnt = 0; m_busy = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) if (resp_ready[i]) m_rv[i] = 1'b0;
            if (m_busy) begin
                m_rv[m_gid] = 1'b1;
                m_rp[m_gid] = 8'(m_a * m_b);
                if (m_cnt < 65535) m_cnt++;
                m_busy = 1'b0;
            end else if (w >= 0) begin
                m_a    = int'(req_a[4*w +: 4]);
                m_b    = int'(req_b[4*w +: 4]);
                m_gid  = w;
                m_ptr  = (w + 1) % N;
                m_busy = 1'b1;
            end
        end
    end

    initial begin : stim
        int t;
        rst        = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 4'h0;
        req_a      = '0;
        req_b      = '0;

        // Reset held two cycles with every requester valid
        tick(2);
        chk("rst_ready",  64'(req_ready),  64'(0));
        chk("rst_rvalid", 64'(resp_valid), 64'(0));
        chk("rst_count",  64'(op_count),   64'(0));
        chk("rst_busy",   64'(busy),       64'(0));
        rst = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'(4'b0001));
        req_valid = 4'h0;
        acc_id.delete();
        acc_cyc.delete();

        // Round robin: operands i*3 and 5
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4] = 4'(i * 3);
            req_b[4*i +: 4] = 4'd5;
        end
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        tick(9);
        req_valid  = 4'h0;
        resp_ready = 4'h0;
        tick(1);
        chk("rr_prod",   64'(resp_p),     64'(32'h2D1E_0F00));
        chk("rr_rvalid", 64'(resp_valid), 64'(4'b0001));
        chk("rr_count",  64'(op_count),   64'(5));
        chk("rr_n",      64'(acc_id.size()), 64'(5));
        for (int k = 0; k < 5 && k < acc_id.size(); k++) begin
            chk("rr_id", 64'(acc_id[k]), 64'(k % N));
            if (k > 0) chk("rr_gap", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(2));
        end
        resp_ready = 4'hF;
        tick(1);
        resp_ready = 4'h0;

        // Single request from requester 2, 15*15, response left unconsumed
        req_a[11:8] = 4'd15;
        req_b[11:8] = 4'd15;
        req_valid   = 4'b0100;
        #1;
        chk("sg_ready", 64'(req_ready), 64'(4'b0100));
        tick(1);
        chk("sg_busy",  64'(busy),      64'(1));
        tick(1);
        chk("sg_rvalid", 64'(resp_valid),   64'(4'b0100));
        chk("sg_prod",   64'(resp_p[23:16]), 64'(225));
        chk("sg_count",  64'(op_count),     64'(6));
        chk("sg_block",  64'(req_ready),    64'(0));
        tick(3);
        chk("sg_hold",   64'(resp_valid),   64'(4'b0100));
        chk("sg_hold_p", 64'(resp_p[23:16]), 64'(225));
        chk("sg_block2", 64'(req_ready),    64'(0));
        resp_ready = 4'b0100;
        req_valid  = 4'h0;
        tick(1);
        resp_ready = 4'h0;
        #1;
        chk("sg_clr",  64'(resp_valid),    64'(0));
        chk("sg_keep", 64'(resp_p[23:16]), 64'(225));

        // Blocking: requester 1 holds a product, requester 3 must win
        req_a[7:4]  = 4'd2;
        req_b[7:4]  = 4'd3;
        req_valid   = 4'b0010;
        #1;
        chk("blk_first", 64'(req_ready), 64'(4'b0010));
        tick(1);
        req_a[15:12] = 4'd4;
        req_b[15:12] = 4'd4;
        req_valid    = 4'b1010;
        tick(1);
        chk("blk_ready", 64'(req_ready), 64'(4'b1000));
        tick(2);
        chk("blk_both",  64'(req_ready), 64'(0));
        chk("blk_prods", 64'(resp_p[31:24]), 64'(16));
        resp_ready = 4'b0010;
        #1;
        chk("blk_same",  64'(req_ready), 64'(0));
        tick(1);
        resp_ready = 4'h0;
        #1;
        chk("blk_next",  64'(req_ready), 64'(4'b0010));
        req_valid  = 4'h0;
        resp_ready = 4'hF;
        tick(1);
        resp_ready = 4'h0;

        // Reset during MULT of requester 0 (7*9)
        req_a[3:0] = 4'd7;
        req_b[3:0] = 4'd9;
        req_valid  = 4'b0001;
        tick(1);
        chk("mid_busy", 64'(busy), 64'(1));
        rst       = 1'b0;
        req_valid = 4'h0;
        tick(1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid", 64'(resp_valid), 64'(0));
        chk("mid_prod",   64'(resp_p),     64'(0));
        chk("mid_count",  64'(op_count),   64'(0));
        chk("mid_busy0",  64'(busy),       64'(0));

        // Exhaustive operands on requester 0
        resp_ready = 4'b0001;
        req_valid  = 4'b0001;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req_a[3:0] = 4'(a);
                req_b[3:0] = 4'(b);
                #1;
                t = 0;
                while (!req_ready[0] && t < 10) begin
                    tick(1);
                    t++;
                end
                if (t >= 10) chk("ex_wait", 64'(t), 64'(0));
                tick(1);
            end
        end
        req_valid = 4'h0;
        tick(2);
        chk("ex_count",  64'(op_count),    64'(256));
        chk("ex_sat8",   64'(op_count8),   64'(255));
        chk("ex_last",   64'(resp_p[7:0]), 64'(225));
        resp_ready = 4'h0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
